ir_fetch_queue: RTL

IR_FETCH_QUEUE -- requirements
Module: ir_fetch_queue

---
 rtl/ir_fetch_queue.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ir_fetch_queue.sv
// Instruction fetch queue: a DEPTH-entry FIFO that decodes each instruction as it is
// written. Optional head-opcode legality check is enabled by defining IR_ILLEGAL_DETECT_EN.
module ir_fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  opcode,
  output logic        r_type,
  output logic        i_type,
  output logic        j_type,
  output logic [4:0]  register_one,
  output logic [4:0]  register_two,
  output logic [4:0]  destination_reg,
  output logic [4:0]  shift,
  output logic [5:0]  function_code,
  output logic [31:0] immediate,
  output logic [25:0] memory,
  output logic        write_en,
  input  logic        flush,
  output logic [$clog2(DEPTH):0] count,
  output logic        illegal
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [5:0]  op;
    logic        is_r;
    logic        is_i;
    logic        is_j;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [31:0] imm;
    logic [25:0] mem;
    logic        we;
  } entry_t;

  entry_t          entries [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_q;
  logic            push;
  logic            pop;

  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Decode happens on the write side so the head fields are plain register reads.
  always_comb begin
    dec    = '0;
    dec.pc = in_pc;
    dec.op = in_instr[31:26];
    if (in_instr[31:26] == 6'h00) begin
      dec.is_r = 1'b1;
      dec.rs   = in_instr[25:21];
      dec.rt   = in_instr[20:16];
      dec.rd   = in_instr[15:11];
      dec.sh   = in_instr[10:6];
      dec.fn   = in_instr[5:0];
    end else if (in_instr[31:26] == 6'h02 || in_instr[31:26] == 6'h03) begin
      dec.is_j = 1'b1;
      dec.mem  = in_instr[25:0];
    end else begin
      dec.is_i = 1'b1;
      dec.rs   = in_instr[25:21];
      dec.rd   = in_instr[20:16];
      dec.imm  = {{16{in_instr[15]}}, in_instr[15:0]};
    end

    dec.we = 1'b1;
    if (dec.is_r && in_instr[5:0] == 6'h08) begin
      dec.we = 1'b0;
    end
    case (in_instr[31:26])
      6'h01, 6'h02, 6'h04, 6'h05, 6'h06, 6'h07, 6'h28, 6'h29, 6'h2B: dec.we = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && push) begin
      entries[wr_ptr] <= dec;
    end
  end

  assign head = entries[rd_ptr];

  assign out_pc          = out_valid ? head.pc  : '0;
  assign opcode          = out_valid ? head.op  : '0;
  assign r_type          = out_valid && head.is_r;
  assign i_type          = out_valid && head.is_i;
  assign j_type          = out_valid && head.is_j;
  assign register_one    = out_valid ? head.rs  : '0;
  assign register_two    = out_valid ? head.rt  : '0;
  assign destination_reg = out_valid ? head.rd  : '0;
  assign shift           = out_valid ? head.sh  : '0;
  assign function_code   = out_valid ? head.fn  : '0;
  assign immediate       = out_valid ? head.imm : '0;
  assign memory          = out_valid ? head.mem : '0;
  assign write_en        = out_valid && head.we;

`ifdef IR_ILLEGAL_DETECT_EN
  logic op_unsupported;

  always_comb begin
    op_unsupported = 1'b1;
    if (head.op <= 6'h0F) begin
      op_unsupported = 1'b0;
    end else if (head.op >= 6'h20 && head.op <= 6'h26) begin
      op_unsupported = 1'b0;
    end else if (head.op == 6'h28 || head.op == 6'h29 || head.op == 6'h2B) begin
      op_unsupported = 1'b0;
    end
  end

  assign illegal = out_valid && op_unsupported;
`else
  assign illegal = 1'b0;
`endif

endmodule
